fc_layer: RTL and testbench

- Fully-connected classifier stage directly downstream of the 2x2 max-pool stage.
- Consumes the 8 pooled 12x12 maps as a serial stream of 1152 unsigned values. The stream order is map-major, then row, then column.
- Accumulates weighted sums for all classes in parallel, adds per-class bias, then performs a sequential argmax.
- Presents the class scores and the winning class index to the top-level controller.

---
 rtl/fc_layer.sv | 160 ++++++++++++++++
 tb/tb_fc_layer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer.sv
// Fully-connected classifier: streams pooled values, MACs them against a weight row
// for every class in parallel, adds bias, then picks the highest score one class per cycle.
module fc_layer #(
    parameter int unsigned DATA_WIDTH   = 45,
    parameter int unsigned WEIGHT_WIDTH = 16,
    parameter int unsigned NUM_INPUTS   = 1152,
    parameter int unsigned NUM_CLASSES  = 10,
    parameter int unsigned ACC_WIDTH    = 74,
    parameter int unsigned ADDR_WIDTH   = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                fc_start,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                weight_rd_en,
    output logic [ADDR_WIDTH-1:0]               weight_addr,
    input  logic [NUM_CLASSES*WEIGHT_WIDTH-1:0] weight_data,
    input  logic [NUM_CLASSES*WEIGHT_WIDTH-1:0] bias,
    output logic [NUM_CLASSES*ACC_WIDTH-1:0]    fc_scores,
    output logic [3:0]                          fc_class,
    output logic                                fc_busy,
    output logic                                fc_done
);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_ARGMAX, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] LAST_CNT   = (ADDR_WIDTH+1)'(NUM_INPUTS);
    localparam logic [3:0]          LAST_CLASS = 4'(NUM_CLASSES - 1);

    state_t                           state_q, state_d;
    logic [ADDR_WIDTH:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]            data_q, data_d;
    logic                             mac_vld_q, mac_vld_d;
    logic signed [ACC_WIDTH-1:0]      acc_q [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]      acc_d [NUM_CLASSES];
    logic [NUM_CLASSES*ACC_WIDTH-1:0] scores_q, scores_d;
    logic [3:0]                       class_q, class_d;
    logic [3:0]                       idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]      max_q, max_d;
    logic [3:0]                       best_q, best_d;

    logic                             hs;
    logic                             do_start;
    logic signed [ACC_WIDTH-1:0]      x_ext;
    logic signed [ACC_WIDTH-1:0]      mac_sum [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]      cur;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        mac_vld_d = 1'b0;
        acc_d     = acc_q;
        scores_d  = scores_q;
        class_d   = class_q;
        idx_d     = idx_q;
        max_d     = max_q;
        best_d    = best_q;
        do_start  = 1'b0;

        in_ready = (state_q == S_ACCUM) && (cnt_q < LAST_CNT);
        hs       = in_valid && in_ready;
        if (hs) begin
            data_d    = in_data;
            cnt_d     = cnt_q + 1'b1;
            mac_vld_d = 1'b1;
        end

        // The product term is gated by the pipeline valid so stall cycles add nothing.
        x_ext = ACC_WIDTH'({1'b0, data_q});
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            mac_sum[c] = acc_q[c];
            if (mac_vld_q)
                mac_sum[c] = acc_q[c] +
                             x_ext * ACC_WIDTH'(signed'(weight_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        end

        cur = signed'(scores_q[idx_q*ACC_WIDTH +: ACC_WIDTH]);

        case (state_q)
            S_IDLE: do_start = fc_start;
            S_ACCUM: begin
                acc_d = mac_sum;
                if (cnt_q == LAST_CNT)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                for (int unsigned c = 0; c < NUM_CLASSES; c++)
                    scores_d[c*ACC_WIDTH +: ACC_WIDTH] =
                        mac_sum[c] + ACC_WIDTH'(signed'(bias[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
                idx_d   = '0;
                state_d = S_ARGMAX;
            end
            S_ARGMAX: begin
                if ((idx_q == '0) || (cur > max_q)) begin
                    max_d  = cur;
                    best_d = idx_q;
                end
                if (idx_q == LAST_CLASS) begin
                    class_d = best_d;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                do_start = fc_start;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_start) begin
            state_d   = S_ACCUM;
            cnt_d     = '0;
            mac_vld_d = 1'b0;
            scores_d  = '0;
            class_d   = '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++)
                acc_d[c] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            mac_vld_q <= 1'b0;
            scores_q  <= '0;
            class_q   <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            best_q    <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++)
                acc_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            mac_vld_q <= mac_vld_d;
            scores_q  <= scores_d;
            class_q   <= class_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            best_q    <= best_d;
            acc_q     <= acc_d;
        end
    end

    assign weight_rd_en = hs;
    assign weight_addr  = cnt_q[ADDR_WIDTH-1:0];
    assign fc_scores    = scores_q;
    assign fc_class     = class_q;
    assign fc_busy      = (state_q == S_ACCUM) || (state_q == S_DRAIN) || (state_q == S_ARGMAX);
    assign fc_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fc_layer.sv
// Randomized scoreboard bench for fc_layer: a plain-arithmetic reference model predicts
// scores and argmax per inference; a negedge monitor checks results, latency and addresses.
module tb_fc_layer;

    localparam int NI = 1152;
    localparam int NC = 10;
    localparam int AW = 74;

    logic           clk = 1'b0;
    logic           rst;
    logic           fc_start;
    logic [44:0]    in_data;
    logic           in_valid;
    logic           in_ready;
    logic           weight_rd_en;
    logic [10:0]    weight_addr;
    logic [159:0]   weight_data;
    logic [159:0]   bias_bus;
    logic [739:0]   fc_scores;
    logic [3:0]     fc_class;
    logic           fc_busy;
    logic           fc_done;

    fc_layer #(.DATA_WIDTH(45), .WEIGHT_WIDTH(16), .NUM_INPUTS(NI), .NUM_CLASSES(NC),
               .ACC_WIDTH(AW), .ADDR_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .fc_start(fc_start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .weight_rd_en(weight_rd_en), .weight_addr(weight_addr),
        .weight_data(weight_data), .bias(bias_bus), .fc_scores(fc_scores),
        .fc_class(fc_class), .fc_busy(fc_busy), .fc_done(fc_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [73:0] s [NC];
        logic [3:0]  cls;
    } exp_t;

    logic [44:0]        xin  [NI];
    logic signed [15:0] wmem [NI][NC];
    logic signed [15:0] bv   [NC];
    exp_t               exp_q [$];

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int last_hs = 0;
    int done_cnt = 0;
    int exp_addr = 0;

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
        end
    endtask

    // Weight memory: one-cycle read latency, junk on idle cycles to expose stale products.
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++)
            weight_data[c*16 +: 16] <= weight_rd_en ? wmem[weight_addr][c] : 16'($urandom);
    end

    function automatic void ref_model(output exp_t e);
        logic signed [79:0] acc, xs, ws;
        int best;
        for (int c = 0; c < NC; c++) begin
            acc = {{64{bv[c][15]}}, bv[c]};
            for (int i = 0; i < NI; i++) begin
                xs  = {35'd0, xin[i]};
                ws  = {{64{wmem[i][c][15]}}, wmem[i][c]};
                acc = acc + xs * ws;
            end
            e.s[c] = acc[73:0];
        end
        best = 0;
        for (int c = 1; c < NC; c++)
            if ($signed(e.s[c]) > $signed(e.s[best])) best = c;
        e.cls = 4'(best);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst && weight_rd_en) begin
            chk("weight_addr", {69'd0, weight_addr}, 80'(exp_addr));
            exp_addr++;
        end
        if (in_valid && in_ready) last_hs = ncyc;
        if (fc_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 80'd1, 80'd0);
            end else begin
                e = exp_q.pop_front();
                for (int c = 0; c < NC; c++)
                    chk($sformatf("score%0d", c), {6'd0, fc_scores[c*AW +: AW]}, {6'd0, e.s[c]});
                chk("fc_class", {76'd0, fc_class}, {76'd0, e.cls});
                chk("latency", 80'(ncyc - last_hs), 80'd13);
                chk("addr_count", 80'(exp_addr), 80'(NI));
            end
        end
    end

    task automatic load_bias();
        for (int c = 0; c < NC; c++) bias_bus[c*16 +: 16] = bv[c];
    endtask

    task automatic set_random();
        logic [63:0] r;
        for (int i = 0; i < NI; i++) begin
            r = {$urandom, $urandom};
            xin[i] = r[44:0];
            for (int c = 0; c < NC; c++) wmem[i][c] = 16'($urandom);
        end
        for (int c = 0; c < NC; c++) bv[c] = 16'($urandom);
        load_bias();
    endtask

    task automatic set_ones();
        for (int i = 0; i < NI; i++) begin
            xin[i] = 45'd1;
            for (int c = 0; c < NC; c++) wmem[i][c] = 16'(c);
        end
        for (int c = 0; c < NC; c++) bv[c] = '0;
        load_bias();
    endtask

    task automatic set_neg();
        for (int i = 0; i < NI; i++) begin
            xin[i] = 45'd1 << 44;
            for (int c = 0; c < NC; c++) wmem[i][c] = (c == 3) ? -16'sd32768 : 16'sd0;
        end
        for (int c = 0; c < NC; c++) bv[c] = (c == 5) ? 16'sd7 : 16'sd0;
        load_bias();
    endtask

    task automatic set_tie();
        logic [63:0] r;
        for (int i = 0; i < NI; i++) begin
            r = {$urandom, $urandom};
            xin[i] = r[44:0];
            for (int c = 0; c < NC; c++) wmem[i][c] = '0;
        end
        for (int c = 0; c < NC; c++) bv[c] = (c == 2 || c == 6) ? 16'sd100 : 16'sd0;
        load_bias();
    endtask

    task automatic wait_done();
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == d0) chk("done_timeout", 80'd0, 80'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_inf(input bit gaps, input bit abort, input bit glitch, input bit start_in_done);
        exp_t e;
        int k;
        bit found;
        if (!abort) begin
            ref_model(e);
            exp_q.push_back(e);
        end
        if (start_in_done) begin
            found = 1'b0;
            k = 0;
            while (!found && k < 60) begin
                @(negedge clk);
                found = fc_done;
                k++;
            end
            if (!found) chk("done_wait_timeout", 80'd0, 80'd1);
            fc_start = 1'b1;
            @(posedge clk); #1;
            fc_start = 1'b0;
            chk("restart_busy", {79'd0, fc_busy}, 80'd1);
            chk("restart_ready", {79'd0, in_ready}, 80'd1);
        end else begin
            @(posedge clk); #1;
            fc_start = 1'b1;
            @(posedge clk); #1;
            fc_start = 1'b0;
        end
        exp_addr = 0;
        for (int i = 0; i < NI; i++) begin
            if (gaps) begin
                while ($urandom_range(1) == 1) begin
                    in_valid = 1'b0;
                    in_data  = 45'($urandom);
                    @(posedge clk); #1;
                end
            end
            if (abort && i == 500) begin
                in_valid = 1'b0;
                rst = 1'b0;
                #1;
                chk("abort_ready", {79'd0, in_ready}, 80'd0);
                chk("abort_busy", {79'd0, fc_busy}, 80'd0);
                chk("abort_scores", {79'd0, |fc_scores}, 80'd0);
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_idle_ready", {79'd0, in_ready}, 80'd0);
                repeat (30) @(posedge clk);
                #1;
                return;
            end
            in_valid = 1'b1;
            in_data  = xin[i];
            if (glitch && i == 300) fc_start = 1'b1;
            k = 0;
            while (!in_ready && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            if (!in_ready) begin
                chk("ready_timeout", 80'd0, 80'd1);
                in_valid = 1'b0;
                fc_start = 1'b0;
                return;
            end
            @(posedge clk); #1;
            fc_start = 1'b0;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (glitch) begin
            fc_start = 1'b1;
            @(posedge clk); #1;
            fc_start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        fc_start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        bias_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_ready", {79'd0, in_ready}, 80'd0);
        chk("rst_rd_en", {79'd0, weight_rd_en}, 80'd0);
        chk("rst_busy", {79'd0, fc_busy}, 80'd0);
        chk("rst_done", {79'd0, fc_done}, 80'd0);
        chk("rst_scores", {79'd0, |fc_scores}, 80'd0);
        chk("rst_class", {76'd0, fc_class}, 80'd0);

        set_random(); run_inf(1'b1, 1'b1, 1'b0, 1'b0);
        set_random(); run_inf(1'b0, 1'b0, 1'b0, 1'b0); wait_done();
        set_ones();   run_inf(1'b0, 1'b0, 1'b0, 1'b0); wait_done();
        set_neg();    run_inf(1'b0, 1'b0, 1'b0, 1'b0); wait_done();
        set_tie();    run_inf(1'b1, 1'b0, 1'b0, 1'b0); wait_done();
        set_random(); run_inf(1'b1, 1'b0, 1'b1, 1'b0);
        set_random(); run_inf(1'b0, 1'b0, 1'b0, 1'b1); wait_done();
        set_random(); run_inf(1'b1, 1'b0, 1'b0, 1'b0); wait_done();

        repeat (20) @(posedge clk);
        chk("queue_empty", 80'(exp_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
